// File: rtl/div_pkg.sv
// div_pkg: shared control encodings and sizing helpers for the iterative arithmetic units.
package div_pkg;
    localparam int STATE_W = 2;
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: operand/result handshake between a requester and the divider.
interface seq_divider_if #(parameter int W = 32);
    logic         valid_data;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ack;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    modport master (
        output valid_data, dividend, divisor, ack,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  valid_data, dividend, divisor, ack,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/div_step.sv
// div_step: one restoring-division iteration, shifting in the next dividend bit.
module div_step #(parameter int W = 32) (
    input  logic [W-1:0] rem,
    input  logic         q_msb,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);
    logic [W:0] t;
    // The trial value needs W+1 bits; the restored remainder always fits back into W.
    assign t        = {rem, q_msb};
    assign q_bit    = t >= {1'b0, divisor};
    assign rem_next = q_bit ? W'(t - {1'b0, divisor}) : t[W-1:0];
endmodule

// File: rtl/seq_divider.sv
// seq_divider: unsigned restoring divider producing one quotient bit per clock.
module seq_divider
    import div_pkg::*;
#(
    parameter int W = 32
) (
    input logic         Clock,
    input logic         Reset,
    seq_divider_if.slave bus
);
    localparam int CW = clog2(W);
    state_t        state, state_n;
    logic [W-1:0]  q, rem, dvs, rem_next;
    logic [CW-1:0] count;
    logic          dbz, q_bit;

    div_step #(.W(W)) u_step (
        .rem     (rem),
        .q_msb   (q[W-1]),
        .divisor (dvs),
        .rem_next(rem_next),
        .q_bit   (q_bit)
    );

    always_ff @(posedge Clock) begin
        if (Reset) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (bus.valid_data ? (bus.divisor == '0 ? DONE : CALC) : IDLE)
                : state == CALC ? (count == CW'(W - 1) ? DONE : CALC)
                : state == DONE ? (bus.ack ? IDLE : DONE)
                : IDLE;
    end

    // The quotient register doubles as the dividend shift register during CALC.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            q     <= '0;
            rem   <= '0;
            dvs   <= '0;
            count <= '0;
            dbz   <= 1'b0;
        end else if (state == IDLE && bus.valid_data) begin
            if (bus.divisor == '0) begin
                q   <= '1;
                rem <= bus.dividend;
                dbz <= 1'b1;
            end else begin
                q     <= bus.dividend;
                rem   <= '0;
                dvs   <= bus.divisor;
                count <= '0;
            end
        end else if (state == CALC) begin
            q     <= {q[W-2:0], q_bit};
            rem   <= rem_next;
            count <= count + 1'b1;
        end else if (state == DONE && bus.ack) begin
            dbz <= 1'b0;
        end
    end

    assign bus.busy        = state != IDLE;
    assign bus.done        = state == DONE;
    assign bus.quotient    = q;
    assign bus.remainder   = rem;
    assign bus.div_by_zero = dbz;
endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed vectors, handshake corner cases and a randomized sweep.
module tb_seq_divider;
    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   total = 0;
    int   passed = 0;

    seq_divider_if #(.W(32)) bus ();
    seq_divider #(.W(32)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        logic        hold;
    } vec_t;
    vec_t vecs [0:8];

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    function automatic void check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input logic ez, input logic hold, input string nm);
        int n;
        bus.dividend   = a;
        bus.divisor    = b;
        bus.valid_data = 1'b1;
        bus.ack        = hold;
        tick();
        bus.valid_data = 1'b0;
        check({nm, " busy_after_accept"}, 64'(bus.busy), 64'd1);
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        check({nm, " latency"}, 64'(n), ez ? 64'd0 : 64'd32);
        check({nm, " quotient"}, 64'(bus.quotient), 64'(eq));
        check({nm, " remainder"}, 64'(bus.remainder), 64'(er));
        check({nm, " div_by_zero"}, 64'(bus.div_by_zero), 64'(ez));
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        check({nm, " done_after_ack"}, 64'(bus.done), 64'd0);
        check({nm, " busy_after_ack"}, 64'(bus.busy), 64'd0);
        check({nm, " dbz_after_ack"}, 64'(bus.div_by_zero), 64'd0);
    endtask

    initial begin
        logic [31:0] a, b;
        int n;
        bus.valid_data = 1'b0;
        bus.dividend   = '0;
        bus.divisor    = '0;
        bus.ack        = 1'b0;
        vecs[0] = '{32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 1'b1};
        vecs[1] = '{32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0};
        vecs[2] = '{32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0};
        vecs[3] = '{32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1'b0};
        vecs[4] = '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0};
        vecs[5] = '{32'd12345, 32'd12345, 32'd1, 32'd0, 1'b0, 1'b0};
        vecs[6] = '{32'd0, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0};
        vecs[7] = '{32'hFFFFFFFF, 32'h10000, 32'hFFFF, 32'hFFFF, 1'b0, 1'b0};
        vecs[8] = '{32'd1000000, 32'd3, 32'd333333, 32'd1, 1'b0, 1'b0};

        tick();
        tick();
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset dbz", 64'(bus.div_by_zero), 64'd0);
        check("reset quotient", 64'(bus.quotient), 64'd0);
        check("reset remainder", 64'(bus.remainder), 64'd0);
        Reset = 1'b0;

        for (int i = 0; i < 9; i++)
            do_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z, vecs[i].hold, $sformatf("vec%0d", i));

        // Abort mid-calculation, then run a fresh operation.
        bus.dividend = 32'hFFFFFFFF;
        bus.divisor = 32'd3;
        bus.valid_data = 1'b1;
        tick();
        bus.valid_data = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort quotient", 64'(bus.quotient), 64'd0);
        check("abort remainder", 64'(bus.remainder), 64'd0);
        check("abort dbz", 64'(bus.div_by_zero), 64'd0);
        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, "post_abort");

        // Noise on valid_data/ack during CALC must not disturb the result.
        bus.dividend = 32'd1000000;
        bus.divisor = 32'd3;
        bus.valid_data = 1'b1;
        tick();
        n = 0;
        while (!bus.done && n < 100) begin
            bus.valid_data = n[0];
            bus.dividend   = 32'(n * 77);
            bus.divisor    = 32'(n % 3);
            bus.ack        = n[1];
            tick();
            n++;
        end
        bus.valid_data = 1'b0;
        bus.ack = 1'b0;
        check("noise latency", 64'(n), 64'd32);
        check("noise quotient", 64'(bus.quotient), 64'd333333);
        check("noise remainder", 64'(bus.remainder), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold done", 64'(bus.done), 64'd1);
            check("hold quotient", 64'(bus.quotient), 64'd333333);
            check("hold remainder", 64'(bus.remainder), 64'd1);
        end
        bus.dividend = 32'd50;
        bus.divisor = 32'd5;
        bus.valid_data = 1'b1;
        bus.ack = 1'b1;
        tick();
        bus.valid_data = 1'b0;
        bus.ack = 1'b0;
        check("ack_and_valid done", 64'(bus.done), 64'd0);
        check("ack_and_valid busy", 64'(bus.busy), 64'd0);
        tick();
        check("no_capture busy", 64'(bus.busy), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = 32'd1;
                1: begin a = a | 32'd1; b = a; end
                2: begin a = $urandom_range(0, 1000); b = a + 32'd1 + $urandom_range(0, 1000); end
                default: b = ($urandom >> $urandom_range(0, 31)) | 32'd1;
            endcase
            do_op(a, b, a / b, a % b, 1'b0, 1'b0, "sweep");
            check("sweep identity", 64'(bus.quotient) * 64'(b) + 64'(bus.remainder), 64'(a));
            check("sweep rem_lt_div", 64'(bus.remainder < b), 64'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
